// File: rtl/display_pkg.sv
// display_pkg: shared display widths, colour constants and ROM address sizing
package display_pkg;

    localparam int X_W     = 10;
    localparam int Y_W     = 9;
    localparam int COLOR_W = 16;

    localparam logic [COLOR_W-1:0] WHITE = 16'hffff;
    localparam logic [COLOR_W-1:0] BLACK = 16'h0000;

    function automatic int addr_width(input int frames, input int width, input int height);
        return (frames * width * height > 1) ? $clog2(frames * width * height) : 1;
    endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl: frame-tick driven animation frame index and blink visibility
module sprite_anim_ctrl #(
    parameter int FRAMES     = 1,
    parameter int FRAME_HOLD = 8,
    parameter int BLINK_HOLD = 30,
    parameter int FI_W       = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_tick,
    input  logic            anim_en,
    input  logic            blink_en,
    output logic [FI_W-1:0] frame_idx,
    output logic            visible
);

    localparam int HC_W = $clog2(FRAME_HOLD + 1);
    localparam int BC_W = $clog2(BLINK_HOLD + 1);

    logic [FI_W-1:0] frame_q, frame_d;
    logic [HC_W-1:0] hold_q, hold_d;
    logic [BC_W-1:0] blink_q, blink_d;
    logic            vis_q, vis_d;
    logic            wrap_h, wrap_b, last_f;

    // next state: counters only move on frame_tick so changes land on vsync
    always_comb begin
        wrap_h  = hold_q == HC_W'(FRAME_HOLD - 1);
        wrap_b  = blink_q == BC_W'(BLINK_HOLD - 1);
        last_f  = frame_q == FI_W'(FRAMES - 1);
        hold_d  = !anim_en ? '0 : frame_tick ? (wrap_h ? '0 : hold_q + 1'b1) : hold_q;
        frame_d = (anim_en & frame_tick & wrap_h) ? (last_f ? '0 : frame_q + 1'b1) : frame_q;
        blink_d = !blink_en ? '0 : frame_tick ? (wrap_b ? '0 : blink_q + 1'b1) : blink_q;
        vis_d   = !blink_en ? 1'b1 : (frame_tick & wrap_b) ? ~vis_q : vis_q;
    end

    // state register, reset dominates frame_tick
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
            hold_q  <= '0;
            blink_q <= '0;
            vis_q   <= 1'b1;
        end else begin
            frame_q <= frame_d;
            hold_q  <= hold_d;
            blink_q <= blink_d;
            vis_q   <= vis_d;
        end
    end

    assign frame_idx = frame_q;
    assign visible   = vis_q;

endmodule

// File: rtl/sprite_renderer.sv
// sprite_renderer: keyed, mirrorable, animated sprite overlay with 2-cycle ROM pipeline
module sprite_renderer
    import display_pkg::*;
#(
    parameter int                 WIDTH      = 430,
    parameter int                 HEIGHT     = 92,
    parameter int                 FRAMES     = 1,
    parameter int                 ADDR_W     = 16,
    parameter int                 FRAME_HOLD = 8,
    parameter int                 BLINK_HOLD = 30,
    parameter logic [COLOR_W-1:0] KEY_COLOR  = WHITE,
    parameter logic [COLOR_W-1:0] BG_COLOR   = WHITE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [X_W-1:0]     x,
    input  logic [Y_W-1:0]     y,
    input  logic [X_W-1:0]     posx,
    input  logic [Y_W-1:0]     posy,
    input  logic               enable,
    input  logic               flip_h,
    input  logic               anim_en,
    input  logic               blink_en,
    input  logic               frame_tick,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic [COLOR_W-1:0] color,
    output logic               is_display
);

    localparam int FI_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    logic [FI_W-1:0]    frame_idx;
    logic               visible;
    logic               hit;
    logic [X_W-1:0]     dx;
    logic [Y_W-1:0]     dy;
    logic [ADDR_W-1:0]  col, addr;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               hit_q;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               disp_q, disp_d;

    sprite_anim_ctrl #(
        .FRAMES     (FRAMES),
        .FRAME_HOLD (FRAME_HOLD),
        .BLINK_HOLD (BLINK_HOLD),
        .FI_W       (FI_W)
    ) u_anim (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .anim_en    (anim_en),
        .blink_en   (blink_en),
        .frame_idx  (frame_idx),
        .visible    (visible)
    );

    // stage 0: widened bounds so sprites clipped at the right/bottom edge never wrap
    always_comb begin
        hit = enable & visible
            & ({1'b0, x} >= {1'b0, posx}) & ({1'b0, x} < {1'b0, posx} + (X_W+1)'(WIDTH))
            & ({1'b0, y} >= {1'b0, posy}) & ({1'b0, y} < {1'b0, posy} + (Y_W+1)'(HEIGHT));
        dx = x - posx;
        dy = y - posy;
        col = flip_h ? ADDR_W'(WIDTH - 1) - ADDR_W'(dx) : ADDR_W'(dx);
        addr = ADDR_W'(frame_idx) * ADDR_W'(WIDTH * HEIGHT) + ADDR_W'(dy) * ADDR_W'(WIDTH) + col;
        rom_addr_d = hit ? addr : '0;
        disp_d = hit_q & (rom_data != KEY_COLOR);
        color_d = disp_d ? rom_data : BG_COLOR;
    end

    // pipeline: address register feeds the ROM, colour register catches its data
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr_q <= '0;
            hit_q      <= 1'b0;
            color_q    <= BG_COLOR;
            disp_q     <= 1'b0;
        end else begin
            rom_addr_q <= rom_addr_d;
            hit_q      <= hit;
            color_q    <= color_d;
            disp_q     <= disp_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign color      = color_q;
    assign is_display = disp_q;

endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer: directed plus random scan checked against a pixel-level reference model
module tb_sprite_renderer;

    localparam int          W   = 4;
    localparam int          H   = 2;
    localparam int          F   = 3;
    localparam int          FH  = 2;
    localparam int          BH  = 1;
    localparam int          AW  = 16;
    localparam logic [15:0] KEY = 16'hf00f;
    localparam logic [15:0] BG  = 16'h0bad;

    typedef struct {
        bit          d;
        logic [15:0] c;
    } exp_t;

    logic          clk = 0;
    logic          rst = 1;
    logic [9:0]    x = 0, posx = 10;
    logic [8:0]    y = 0, posy = 5;
    logic          enable = 1, flip_h = 0, anim_en = 0, blink_en = 0, frame_tick = 0;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data, color;
    logic          is_display;
    logic [15:0]   rom [0:F*W*H-1];

    int   n_tests = 0, n_fail = 0;
    int   m_frame = 0, m_hold = 0, m_bcnt = 0;
    bit   m_vis = 1;
    exp_t q[$];

    sprite_renderer #(
        .WIDTH(W), .HEIGHT(H), .FRAMES(F), .ADDR_W(AW),
        .FRAME_HOLD(FH), .BLINK_HOLD(BH), .KEY_COLOR(KEY), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .posx(posx), .posy(posy),
        .enable(enable), .flip_h(flip_h), .anim_en(anim_en), .blink_en(blink_en),
        .frame_tick(frame_tick), .rom_addr(rom_addr), .rom_data(rom_data),
        .color(color), .is_display(is_display)
    );

    always #5 clk = ~clk;

    assign rom_data = (rom_addr < AW'(F*W*H)) ? rom[rom_addr[4:0]] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d posx=%0d posy=%0d)", tag, got, exp, x, y, posx, posy);
        end
    endtask

    // one clock with current inputs: predict, advance the model, clock, compare
    task automatic step();
        int   xi, yi, px, py, c, idx;
        bit   h;
        exp_t e;
        logic [AW-1:0] ea;
        if (rst) begin
            m_frame = 0; m_hold = 0; m_bcnt = 0; m_vis = 1;
            q.delete();
            e.d = 0; e.c = BG;
            q.push_back(e);
            @(posedge clk); #1;
            check("rst_color", color, BG);
            check("rst_disp", is_display, 0);
            check("rst_addr", rom_addr, 0);
            return;
        end
        xi = x; yi = y; px = posx; py = posy;
        h = enable && m_vis && xi >= px && xi < px + W && yi >= py && yi < py + H;
        idx = 0;
        if (h) begin
            c = flip_h ? W - 1 - (xi - px) : xi - px;
            idx = m_frame * W * H + (yi - py) * W + c;
        end
        ea = h ? AW'(idx) : '0;
        e.d = h && rom[idx] != KEY;
        e.c = e.d ? rom[idx] : BG;
        q.push_back(e);
        if (!anim_en) m_hold = 0;
        else if (frame_tick) begin
            if (m_hold == FH - 1) begin
                m_hold = 0;
                m_frame = (m_frame == F - 1) ? 0 : m_frame + 1;
            end else m_hold++;
        end
        if (!blink_en) begin
            m_vis = 1; m_bcnt = 0;
        end else if (frame_tick) begin
            if (m_bcnt == BH - 1) begin
                m_bcnt = 0; m_vis = !m_vis;
            end else m_bcnt++;
        end
        @(posedge clk); #1;
        check("rom_addr", rom_addr, ea);
        if (q.size() == 2) begin
            e = q.pop_front();
            check("color", color, e.c);
            check("is_display", is_display, e.d);
        end
    endtask

    task automatic scan(input int xv, input int yv);
        x = 10'(xv); y = 9'(yv);
        step();
    endtask

    task automatic tick();
        frame_tick = 1; step();
        frame_tick = 0;
    endtask

    initial begin
        for (int i = 0; i < F*W*H; i++) rom[i] = 16'(i);
        rom[2] = KEY;
        rom[13] = KEY;
        step(); step();
        rst = 0;
        for (int i = 10; i <= 14; i++) scan(i, 5);
        flip_h = 1;
        for (int i = 10; i <= 13; i++) scan(i, 6);
        flip_h = 0;
        for (int i = 11; i <= 13; i++) scan(i, 5);
        scan(0, 0); scan(0, 0);
        anim_en = 1;
        for (int t = 0; t < 6; t++) begin
            tick();
            scan(10, 5); scan(11, 6); scan(0, 0);
        end
        anim_en = 0; blink_en = 1;
        for (int t = 0; t < 3; t++) begin
            tick();
            scan(10, 5); scan(13, 6); scan(0, 0);
        end
        blink_en = 0;
        scan(10, 5); scan(12, 6); scan(0, 0);
        posx = 1020;
        for (int i = 1018; i <= 1029; i++) scan(i % 1024, 5);
        scan(0, 0); scan(0, 0);
        anim_en = 1; posx = 10;
        while (m_frame != 2) begin
            tick();
            scan(10, 5);
        end
        scan(11, 5);
        rst = 1; frame_tick = 1; step();
        rst = 0; frame_tick = 0;
        scan(10, 5); scan(11, 5); scan(0, 0);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                case ($urandom_range(0, 3))
                    0: begin posx = 10; posy = 5; end
                    1: begin posx = 10'(1020 + $urandom_range(0, 3)); posy = 9'($urandom_range(0, 511)); end
                    2: begin posx = 10'($urandom); posy = 9'(509 + $urandom_range(0, 2)); end
                    default: begin posx = 10'($urandom); posy = 9'($urandom); end
                endcase
            end
            x = 10'(int'(posx) + int'($urandom_range(0, W + 3)) - 2);
            y = 9'(int'(posy) + int'($urandom_range(0, H + 1)) - 1);
            flip_h     = 1'($urandom);
            enable     = $urandom_range(0, 9) != 0;
            anim_en    = $urandom_range(0, 19) != 0;
            blink_en   = $urandom_range(0, 3) == 0;
            frame_tick = $urandom_range(0, 7) == 0;
            rst        = $urandom_range(0, 299) == 0;
            step();
        end
        rst = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_renderer.md
Name: sprite_renderer

Overview:
- Parametrised successor to the single-image title overlay.
- Renders one WIDTH x HEIGHT sprite with FRAMES animation frames from an external synchronous ROM, positioned at (posx, posy) on the VGA scan.
- Adds colour-key transparency, horizontal mirroring, frame-tick-driven animation and blinking, and a 2-cycle pipeline aligned to the registered ROM read.
- Output feeds the layer mixer in the display path.

Parameters:
- WIDTH, 430: sprite width in pixels.
- HEIGHT, 92: sprite height in pixels.
- FRAMES, 1: number of animation frames stored back-to-back in ROM (frame k base = k*WIDTH*HEIGHT).
- ADDR_W, 16: ROM address width; must satisfy 2^ADDR_W >= FRAMES*WIDTH*HEIGHT.
- FRAME_HOLD, 8: frame_tick pulses per animation frame (>=1).
- BLINK_HOLD, 30: frame_tick pulses per blink half-period (>=1).
- KEY_COLOR, 16'hffff: ROM value treated as transparent.
- BG_COLOR, 16'hffff: colour driven when the sprite does not cover the pixel.

Ports:
- clk  in  1  pixel-domain clock.
- rst  in  1  synchronous, active-high reset.
- x  in  10  scan x from vgac.
- y  in  9  scan y from vgac.
- posx  in  10  sprite left edge.
- posy  in  9  sprite top edge.
- enable  in  1  sprite shown when high.
- flip_h  in  1  mirror horizontally.
- anim_en  in  1  advance frames on frame_tick.
- blink_en  in  1  toggle visibility on frame_tick.
- frame_tick  in  1  one-cycle pulse per video frame (vsync start).
- rom_addr  out  ADDR_W  registered ROM address.
- rom_data  in  16  ROM word, valid one cycle after rom_addr.
- color  out  16  registered pixel colour.
- is_display  out  1  registered: sprite owns this pixel.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) sets:
  - color=BG_COLOR, is_display=0, rom_addr=0.
  - frame_idx=0, hold_cnt=0, blink_cnt=0, visible=1.
- Stage 0, combinational:
  - hit = enable & visible & x>=posx & x<posx+WIDTH & y>=posy & y<posy+HEIGHT.
  - Compares use 11-bit x and 10-bit y extensions, so posx+WIDTH beyond 1023 does not wrap; clipped sprites must render correctly.
  - col = flip_h ? WIDTH-1-(x-posx) : x-posx.
  - row = y-posy.
  - addr = frame_idx*WIDTH*HEIGHT + row*WIDTH + col, computed at ADDR_W and truncated.
- Edge 1:
  - rom_addr<=addr; hit_d<=hit.
  - When hit=0, rom_addr<=0, so the ROM sees no stale address.
- Edge 2:
  - When hit_d & rom_data!=KEY_COLOR: color<=rom_data; is_display<=1.
  - Otherwise: color<=BG_COLOR; is_display<=0.
- Latency: 2 clk from x/y to color/is_display. The upstream sync delay must match.
- Animation counter:
  - On frame_tick with anim_en=1: if hold_cnt==FRAME_HOLD-1, set hold_cnt=0 and frame_idx=(frame_idx==FRAMES-1)?0:frame_idx+1. Otherwise hold_cnt++.
  - anim_en=0: frame_idx holds; hold_cnt clears to 0.
  - FRAMES=1: frame_idx stays 0.
- Blink counter:
  - On frame_tick with blink_en=1: if blink_cnt==BLINK_HOLD-1, set blink_cnt=0 and toggle visible. Otherwise blink_cnt++.
  - blink_en=0: visible=1 and blink_cnt=0 on the next edge.
- Timing of state changes:
  - frame_idx and visible change only at the edge where frame_tick=1 (vsync), so there is no mid-frame tearing.
  - Pixels already in the pipeline complete with the old frame.
- rst and frame_tick together: rst wins.
- Mid-line changes to posx, posy or flip_h take effect for the pixel sampled that cycle. No shadow registering is done.

Decomposition:
- display_pkg holds:
  - X_W=10, Y_W=9, COLOR_W=16.
  - Colour constants (WHITE=16'hffff, BLACK=16'h0000).
  - A function that computes the address width from FRAMES, WIDTH and HEIGHT.
- Sub-module sprite_anim_ctrl holds frame_idx, hold_cnt, blink_cnt and visible.
  - Ports: clk, rst, frame_tick, anim_en, blink_en, frame_idx, visible.
- sprite_renderer holds the hit test, address generation and the 2-stage pipeline.

Test Plan:
1. WIDTH=4, HEIGHT=2, FRAMES=1, posx=10, posy=5, ROM=index:
   - Scan (10..13, 5) -> two cycles later color=0,1,2,3, is_display=1.
   - Scan (14, 5) -> color=BG, is_display=0.
2. Same setup with flip_h=1:
   - Scan (10..13, 6) -> color=7,6,5,4.
3. ROM word at index 2 = KEY_COLOR:
   - Scan (12, 5) -> is_display=0, color=BG.
   - Neighbours unaffected.
4. FRAMES=3, FRAME_HOLD=2, anim_en=1, pulse frame_tick 6 times:
   - frame_idx sequence 0,0,1,1,2,2,0.
   - Pixel (10, 5) after the 2nd tick reads ROM address 8.
5. BLINK_HOLD=1, blink_en=1, three ticks:
   - visible 0,1,0; during invisible frames is_display stays 0.
   - Drop blink_en -> visible=1 next edge.
6. posx=1020, WIDTH=4:
   - x=1020..1023 hit, x=0..3 no hit (no wrap).
   - Assert rst mid-animation at frame_idx=2 -> next edge frame_idx=0, color=BG, is_display=0.
